// File: rtl/mux_serializer.sv
// mux_serializer: handshake-driven parallel-in, serial-out stage stepping a select index across a captured word
module mux_serializer #(
    parameter int WIDTH     = 8,
    parameter int SEL_W     = $clog2(WIDTH),
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] sel,
    output logic             done
);
    typedef enum logic {IDLE, SEND} state_t;
    localparam logic [SEL_W-1:0] FIRST = MSB_FIRST ? SEL_W'(WIDTH-1) : '0;
    localparam logic [SEL_W-1:0] LAST  = MSB_FIRST ? '0 : SEL_W'(WIDTH-1);
    state_t state, state_n;
    logic [WIDTH-1:0] data, data_n;
    logic [SEL_W-1:0] sel_n;
    logic load, beat, last, done_n;
    // state, word, index and done registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            data  <= '0;
            sel   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            data  <= data_n;
            sel   <= sel_n;
            done  <= done_n;
        end
    end
    // handshake decode, next state and the selected serial bit
    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == SEND;
        out       = out_valid ? data[sel] : 1'b0;
        load      = in_valid && in_ready;
        beat      = out_valid && out_ready;
        last      = sel == LAST;
        state_n   = load ? SEND : (beat && last) ? IDLE : state;
        data_n    = load ? in : data;
        sel_n     = load ? FIRST
                  : (beat && !last) ? (MSB_FIRST ? sel - SEL_W'(1) : sel + SEL_W'(1))
                  : sel;
        done_n    = beat && last;
    end
endmodule

// File: tb/tb_mux_serializer.sv
// tb_mux_serializer: directed checks of an LSB-first and an MSB-first serializer
module tb_mux_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] in = '0, m_in = '0;
    logic in_valid = 1'b0, m_in_valid = 1'b0;
    logic out_ready = 1'b1, m_out_ready = 1'b1;
    logic in_ready, out, out_valid, done;
    logic m_in_ready, m_out, m_out_valid, m_done;
    logic [2:0] sel, m_sel;
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    mux_serializer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_ready(in_ready),
        .out(out), .out_valid(out_valid), .out_ready(out_ready), .sel(sel), .done(done)
    );

    mux_serializer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .in(m_in), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .out(m_out), .out_valid(m_out_valid), .out_ready(m_out_ready), .sel(m_sel), .done(m_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] w);
        in = w;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // called one cycle after the load edge; walks all eight beats then checks the done pulse
    task automatic beats(input logic [7:0] w, input int stall_at, input int stall_n, input bit junk);
        for (int i = 0; i < 8; i++) begin
            chk("out", {31'b0, out}, {31'b0, w[i]});
            chk("sel", {29'b0, sel}, i);
            chk("out_valid", {31'b0, out_valid}, 1);
            chk("in_ready_send", {31'b0, in_ready}, 0);
            chk("done_send", {31'b0, done}, 0);
            if (junk && i == 0) begin
                in = 8'hFF;
                in_valid = 1'b1;
            end
            if (i == stall_at) begin
                out_ready = 1'b0;
                repeat (stall_n) begin
                    step();
                    chk("stall_sel", {29'b0, sel}, i);
                    chk("stall_out", {31'b0, out}, {31'b0, w[i]});
                    chk("stall_valid", {31'b0, out_valid}, 1);
                end
                out_ready = 1'b1;
            end
            if (junk && i == 7) in_valid = 1'b0;
            step();
        end
        chk("done", {31'b0, done}, 1);
        chk("in_ready_done", {31'b0, in_ready}, 1);
        chk("sel_hold", {29'b0, sel}, 7);
    endtask

    initial begin
        step();
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_out", {31'b0, out}, 0);
        chk("rst_sel", {29'b0, sel}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_msb_sel", {29'b0, m_sel}, 0);
        rst = 1'b0;
        step();

        load(8'b1011_0010);
        beats(8'b1011_0010, -1, 0, 1'b0);
        step();
        chk("done_once", {31'b0, done}, 0);

        m_in = 8'hA5;
        m_in_valid = 1'b1;
        step();
        m_in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("msb_out", {31'b0, m_out}, {31'b0, m_in[7-i]});
            chk("msb_sel", {29'b0, m_sel}, 7 - i);
            chk("msb_valid", {31'b0, m_out_valid}, 1);
            step();
        end
        chk("msb_done", {31'b0, m_done}, 1);
        chk("msb_sel_hold", {29'b0, m_sel}, 0);
        chk("msb_in_ready", {31'b0, m_in_ready}, 1);
        step();
        chk("msb_done_once", {31'b0, m_done}, 0);

        load(8'hF0);
        beats(8'hF0, 3, 3, 1'b0);
        step();
        chk("bp_done_once", {31'b0, done}, 0);

        load(8'h00);
        beats(8'h00, -1, 0, 1'b1);
        step();
        chk("junk_idle", {31'b0, out_valid}, 0);

        load(8'h5A);
        repeat (5) step();
        chk("mid_sel", {29'b0, sel}, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_out_valid", {31'b0, out_valid}, 0);
        chk("mid_in_ready", {31'b0, in_ready}, 1);
        chk("mid_sel0", {29'b0, sel}, 0);
        chk("mid_out", {31'b0, out}, 0);
        chk("mid_done", {31'b0, done}, 0);
        step();
        chk("mid_no_done", {31'b0, done}, 0);
        load(8'h3C);
        beats(8'h3C, -1, 0, 1'b0);
        step();

        in = 8'h01;
        in_valid = 1'b1;
        step();
        in = 8'h80;
        beats(8'h01, -1, 0, 1'b0);
        chk("b2b_idle_out", {31'b0, out}, 0);
        chk("b2b_idle_valid", {31'b0, out_valid}, 0);
        step();
        in_valid = 1'b0;
        beats(8'h80, -1, 0, 1'b0);
        step();
        chk("b2b_done_once", {31'b0, done}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
